// File: rtl/circle_ctrl.sv
// Circle sequencer: clears the screen in column-major order, then hands the VGA port
// to a downstream circle drawer until it reports completion.
module circle_ctrl #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic [2:0] colour,
  output logic       done,
  output logic       circ_start,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  output logic [2:0] circ_colour,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_vga_colour,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  state_t     state;
  logic [7:0] col;
  logic [6:0] row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      done          <= 1'b0;
      circ_start    <= 1'b0;
      circ_centre_x <= '0;
      circ_centre_y <= '0;
      circ_radius   <= '0;
      circ_colour   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          circ_start <= 1'b0;
          if (start) begin
            circ_centre_x <= centre_x;
            circ_centre_y <= centre_y;
            circ_radius   <= radius;
            circ_colour   <= colour;
            col           <= '0;
            row           <= '0;
            state         <= CLEAR;
          end
        end
        CLEAR: begin
          // Dropping start freezes the counters where they are; they restart from IDLE.
          if (!start) begin
            state <= IDLE;
          end else if (row == LAST_ROW) begin
            row <= '0;
            if (col == LAST_COL) begin
              state      <= DRAW;
              circ_start <= 1'b1;
            end else begin
              col <= col + 8'd1;
            end
          end else begin
            row <= row + 7'd1;
          end
        end
        DRAW: begin
          // An abort takes priority over a coincident circ_done.
          if (!start) begin
            state      <= IDLE;
            circ_start <= 1'b0;
          end else if (circ_done) begin
            state      <= DONE;
            circ_start <= 1'b0;
            done       <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    case (state)
      CLEAR: begin
        vga_x      = col;
        vga_y      = row;
        vga_colour = CLEAR_COLOUR;
        vga_plot   = 1'b1;
      end
      DRAW: begin
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_circle_ctrl.sv
// Bench for circle_ctrl: pixel-index reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_circle_ctrl;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int TOTAL = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] radius = '0;
  logic [2:0] colour = '0;
  logic       done, circ_start;
  logic [7:0] circ_centre_x, circ_radius;
  logic [6:0] circ_centre_y;
  logic [2:0] circ_colour;
  logic       circ_done = 1'b0;
  logic [7:0] circ_x = '0;
  logic [6:0] circ_y = '0;
  logic [2:0] circ_vga_colour = '0;
  logic       circ_plot = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int checks = 0;
  int errors = 0;

  circle_ctrl #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .done(done), .circ_start(circ_start),
    .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
    .circ_radius(circ_radius), .circ_colour(circ_colour),
    .circ_done(circ_done), .circ_x(circ_x), .circ_y(circ_y),
    .circ_vga_colour(circ_vga_colour), .circ_plot(circ_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 clearing pixel k (column-major), 2 drawing, 3 finished.
  int         phase = 0;
  int         k = 0;
  logic [7:0] m_cx = '0, m_r = '0;
  logic [6:0] m_cy = '0;
  logic [2:0] m_col = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; k <= 0; m_cx <= '0; m_cy <= '0; m_r <= '0; m_col <= '0;
    end else begin
      case (phase)
        0: if (start) begin
          m_cx <= centre_x; m_cy <= centre_y; m_r <= radius; m_col <= colour;
          k <= 0; phase <= 1;
        end
        1: if (!start) phase <= 0;
           else if (k == TOTAL - 1) phase <= 2;
           else k <= k + 1;
        2: if (!start) phase <= 0;
           else if (circ_done) phase <= 3;
        default: if (!start) phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
    ex = '0; ey = '0; ec = '0; ep = 1'b0;
    if (phase == 1) begin
      ex = 8'(k / H); ey = 7'(k % H); ec = 3'b000; ep = 1'b1;
    end else if (phase == 2) begin
      ex = circ_x; ey = circ_y; ec = circ_vga_colour; ep = circ_plot;
    end
    check("vga_x", 32'(vga_x), 32'(ex));
    check("vga_y", 32'(vga_y), 32'(ey));
    check("vga_colour", 32'(vga_colour), 32'(ec));
    check("vga_plot", 32'(vga_plot), 32'(ep));
    check("done", 32'(done), 32'(phase == 3));
    check("circ_start", 32'(circ_start), 32'(phase == 2));
    check("circ_centre_x", 32'(circ_centre_x), 32'(m_cx));
    check("circ_centre_y", 32'(circ_centre_y), 32'(m_cy));
    check("circ_radius", 32'(circ_radius), 32'(m_r));
    check("circ_colour", 32'(circ_colour), 32'(m_col));
  end

  // Drawer stand-in: counts circ_start cycles, streams a pattern, pulses circ_done at 50.
  bit drawer_on = 1'b0;
  int dcnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (drawer_on) begin
      if (circ_start) dcnt++;
      circ_done       = circ_start && (dcnt == 50);
      circ_x          = 8'(dcnt * 3);
      circ_y          = 7'(dcnt);
      circ_vga_colour = 3'(dcnt);
      circ_plot       = dcnt[0];
    end
  endtask

  bit seen [TOTAL];

  task automatic clear_phase(input bit spurious, output int npix, output int uncovered,
                             output int fx, output int fy, output int lx, output int ly);
    foreach (seen[i]) seen[i] = 1'b0;
    npix = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < TOTAL + 50; i++) begin
      tick();
      if (circ_start) break;
      if (vga_plot) begin
        if (npix == 0) begin fx = vga_x; fy = vga_y; end
        lx = vga_x; ly = vga_y;
        if (int'(vga_x) < W && int'(vga_y) < H) seen[int'(vga_x) * H + int'(vga_y)] = 1'b1;
        npix++;
      end
      if (spurious) circ_done = (npix >= 100 && npix < 104);
    end
    circ_done = 1'b0;
    uncovered = 0;
    foreach (seen[i]) if (!seen[i]) uncovered++;
  endtask

  initial begin
    int npix, unc, fx, fy, lx, ly;
    bit saw_start;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("reset_done", 32'(done), 32'd0);
    check("reset_circ_start", 32'(circ_start), 32'd0);
    check("reset_vga_plot", 32'(vga_plot), 32'd0);
    check("reset_circ_centre_x", 32'(circ_centre_x), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full clear with spurious circ_done, then a 50-cycle draw.
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd10; colour = 3'b010;
    start = 1'b1;
    clear_phase(1'b1, npix, unc, fx, fy, lx, ly);
    check("clear_count", 32'(npix), 32'd19200);
    check("clear_uncovered", 32'(unc), 32'd0);
    check("clear_first", {16'(fx), 16'(fy)}, {16'd0, 16'd0});
    check("clear_last", {16'(lx), 16'(ly)}, {16'd159, 16'd119});
    check("circ_start_after_clear", 32'(circ_start), 32'd1);
    check("latched_radius", 32'(circ_radius), 32'd10);
    check("latched_colour", 32'(circ_colour), 32'b010);
    dcnt = 0; drawer_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 10) begin
        centre_x = 8'd20;
        check("centre_x_held", 32'(circ_centre_x), 32'd80);
      end
      if (done) break;
    end
    check("draw_done", 32'(done), 32'd1);
    check("draw_len", 32'(dcnt), 32'd50);
    check("done_circ_start", 32'(circ_start), 32'd0);
    check("done_vga_plot", 32'(vga_plot), 32'd0);
    drawer_on = 1'b0; circ_done = 1'b0;
    start = 1'b0;
    tick();
    check("idle_done", 32'(done), 32'd0);

    // Abort mid-clear, then restart from (0,0).
    centre_x = 8'd80;
    tick();
    start = 1'b1;
    repeat (5000) tick();
    start = 1'b0;
    tick();
    check("abort_vga_plot", 32'(vga_plot), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    saw_start = 1'b0;
    repeat (20) begin
      tick();
      if (circ_start || done) saw_start = 1'b1;
    end
    check("abort_no_start", 32'(saw_start), 32'd0);
    start = 1'b1;
    clear_phase(1'b0, npix, unc, fx, fy, lx, ly);
    check("restart_first", {16'(fx), 16'(fy)}, {16'd0, 16'd0});
    check("restart_count", 32'(npix), 32'd19200);

    // Asynchronous reset in the middle of DRAW.
    dcnt = 0; drawer_on = 1'b1;
    repeat (10) tick();
    check("pre_reset_circ_start", 32'(circ_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_done", 32'(done), 32'd0);
    check("async_circ_start", 32'(circ_start), 32'd0);
    check("async_vga_plot", 32'(vga_plot), 32'd0);
    start = 1'b0; drawer_on = 1'b0; circ_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_reset_idle_plot", 32'(vga_plot), 32'd0);
    check("post_reset_circ_start", 32'(circ_start), 32'd0);
    check("post_reset_centre_x", 32'(circ_centre_x), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
